alu_acc_ctrl: RTL and testbench

//  Command sequencer and accumulator that sits around the 4-bit ALU (alu4bit).

---
 rtl/alu_acc_ctrl_if.sv | 27 ++
 rtl/alu_acc_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_acc_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_acc_ctrl_if.sv
// Command/result handshake bundle for alu_acc_ctrl.
// master = command producer / result consumer, slave = alu_acc_ctrl.
`timescale 1ns/1ps
interface alu_acc_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cin, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cin, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Command sequencer and accumulator wrapped around the external 4-bit ALU (alu4bit).
// Optional macro ALU_ACC_CARRY_CHAIN_EN: ADD takes its carry-in from the stored carry flag.
`timescale 1ns/1ps
module alu_acc_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_acc_ctrl_if.slave    bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_ADD  = 3'b011,
        OP_LOAD = 3'b100,
        OP_CLR  = 3'b101
    } op_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [WIDTH-1:0] opnd;
    logic             cin_r;
    logic [1:0]       sel_r;
    logic [2:0]       op_r;
    logic             cmd_ready_r;
    logic             res_valid_r;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            carry       <= 1'b0;
            opnd        <= '0;
            cin_r       <= 1'b0;
            sel_r       <= 2'b00;
            op_r        <= '0;
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        opnd        <= bus.cmd_data;
                        sel_r       <= bus.cmd_op[1:0];
                        op_r        <= bus.cmd_op;
`ifdef ALU_ACC_CARRY_CHAIN_EN
                        // carry only changes in EXEC, so sampling it at accept equals its EXEC value
                        cin_r       <= (bus.cmd_op == OP_ADD) ? carry : bus.cmd_cin;
`else
                        cin_r       <= bus.cmd_cin;
`endif
                        cmd_ready_r <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_r)
                        OP_AND, OP_OR, OP_XOR: begin
                            acc   <= alu_y;
                            carry <= 1'b0;
                        end
                        OP_ADD: begin
                            acc   <= alu_y;
                            carry <= alu_cout;
                        end
                        OP_LOAD: acc <= opnd;
                        OP_CLR: begin
                            acc   <= '0;
                            carry <= 1'b0;
                        end
                        default: ;
                    endcase
                    res_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        cnt         <= cnt + 1'b1;
                        res_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign alu_a         = acc;
    assign alu_b         = opnd;
    assign alu_cin       = cin_r;
    assign alu_sel       = sel_r;
    assign op_count      = cnt;
    assign bus.cmd_ready = cmd_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = acc;
    assign bus.res_carry = carry;
    assign bus.res_zero  = (acc == '0);
endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl with a behavioural alu4bit stand-in.
// Honours ALU_ACC_CARRY_CHAIN_EN for the carry-dependent expectations.
`timescale 1ns/1ps
module tb_alu_acc_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alu_a, alu_b, alu_y;
    logic       alu_cin, alu_cout;
    logic [1:0] alu_sel;
    logic [7:0] op_count;
    logic [4:0] sum;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_cnt;
    logic [3:0] exp_acc;
    logic       exp_car;

    always #5 clk = ~clk;

    alu_acc_ctrl_if #(.WIDTH(4)) bus ();

    alu_acc_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_sel  (alu_sel),
        .alu_y    (alu_y),
        .alu_cout (alu_cout),
        .op_count (op_count)
    );

    always_comb begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_y    = '0;
        alu_cout = 1'b0;
        case (alu_sel)
            2'b00: alu_y = alu_a & alu_b;
            2'b01: alu_y = alu_a | alu_b;
            2'b10: alu_y = alu_a ^ alu_b;
            default: begin
                alu_y    = sum[3:0];
                alu_cout = sum[4];
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command with res_ready high and check every cycle up to the handshake.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic cin,
                           input logic [3:0] e_data, input logic e_carry);
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_cin   = cin;
        bus.cmd_valid = 1'b1;
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        chk("exec_res_valid", bus.res_valid, 0);
        chk("exec_cmd_ready", bus.cmd_ready, 0);
        chk("exec_alu_a", alu_a, exp_acc);
        chk("exec_alu_b", alu_b, data);
        chk("exec_alu_sel", alu_sel, op[1:0]);
        if (op == 3'b011) begin
`ifdef ALU_ACC_CARRY_CHAIN_EN
            chk("exec_alu_cin", alu_cin, exp_car);
`else
            chk("exec_alu_cin", alu_cin, cin);
`endif
        end
        step();
        chk("resp_res_valid", bus.res_valid, 1);
        chk("resp_cmd_ready", bus.cmd_ready, 0);
        chk("resp_res_data", bus.res_data, e_data);
        chk("resp_res_carry", bus.res_carry, e_carry);
        chk("resp_res_zero", bus.res_zero, (e_data == 4'd0));
        step();
        exp_cnt++;
        chk("done_res_valid", bus.res_valid, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        chk("done_op_count", op_count, exp_cnt);
        exp_acc = e_data;
        exp_car = e_carry;
    endtask

    initial begin
        // T1 reset
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 4'h0;
        bus.cmd_cin   = 1'b0;
        bus.res_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_acc = 4'h0;
        exp_car = 1'b0;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_carry", bus.res_carry, 0);
        chk("rst_res_zero", bus.res_zero, 1);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_cin", alu_cin, 0);

        // T2 logic ops
        run_cmd(3'b100, 4'b1010, 1'b0, 4'b1010, 1'b0);
        run_cmd(3'b000, 4'b0011, 1'b0, 4'b0010, 1'b0);
        run_cmd(3'b001, 4'b0011, 1'b0, 4'b0011, 1'b0);
        run_cmd(3'b010, 4'b0011, 1'b0, 4'b0000, 1'b0);

        // T3 add with carry, then carry feed-forward case
        run_cmd(3'b100, 4'b1111, 1'b0, 4'b1111, 1'b0);
`ifdef ALU_ACC_CARRY_CHAIN_EN
        run_cmd(3'b011, 4'b0001, 1'b1, 4'b0000, 1'b1);
        run_cmd(3'b100, 4'b0000, 1'b0, 4'b0000, 1'b1);
        run_cmd(3'b011, 4'b0000, 1'b0, 4'b0001, 1'b0);
`else
        run_cmd(3'b011, 4'b0001, 1'b1, 4'b0001, 1'b1);
        run_cmd(3'b100, 4'b0000, 1'b0, 4'b0000, 1'b1);
        run_cmd(3'b011, 4'b0000, 1'b0, 4'b0000, 1'b0);
`endif
        // reserved op is a NOP, ADD overflow, CLR
        run_cmd(3'b100, 4'b0101, 1'b0, 4'b0101, 1'b0);
        run_cmd(3'b110, 4'b1111, 1'b1, 4'b0101, 1'b0);
        run_cmd(3'b011, 4'b1100, 1'b0, 4'b0001, 1'b1);
        run_cmd(3'b101, 4'b1010, 1'b0, 4'b0000, 1'b0);

        // T4 backpressure
        bus.res_ready = 1'b0;
        bus.cmd_op    = 3'b100;
        bus.cmd_data  = 4'b1001;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("bp_res_valid_start", bus.res_valid, 1);
        bus.cmd_data  = 4'b0110;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_data", bus.res_data, 4'b1001);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_op_count", op_count, exp_cnt);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        exp_cnt++;
        chk("bp_rel_res_valid", bus.res_valid, 0);
        chk("bp_rel_op_count", op_count, exp_cnt);
        chk("bp_rel_res_data", bus.res_data, 4'b1001);
        chk("bp_rel_cmd_ready", bus.cmd_ready, 1);
        step();
        chk("bp_idle_res_valid", bus.res_valid, 0);
        chk("bp_idle_op_count", op_count, exp_cnt);
        exp_acc = 4'b1001;

        // T5 reset during EXEC
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_acc = 4'h0;
        exp_car = 1'b0;
        chk("t5_pre_op_count", op_count, 0);
        bus.cmd_op    = 3'b100;
        bus.cmd_data  = 4'b0111;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk("t5_in_exec", bus.cmd_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_res_valid", bus.res_valid, 0);
        chk("t5_cmd_ready", bus.cmd_ready, 1);
        chk("t5_res_data", bus.res_data, 0);
        chk("t5_res_zero", bus.res_zero, 1);
        chk("t5_op_count", op_count, 0);
        step();
        chk("t5_no_pulse", bus.res_valid, 0);
        chk("t5_op_count_hold", op_count, 0);

        // T6 256 loads wrap the counter
        for (int i = 0; i < 256; i++) begin
            run_cmd(3'b100, i[3:0], 1'b0, i[3:0], 1'b0);
        end
        chk("t6_wrap", op_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
